// File: rtl/bit_plotter_pkg.sv
// Shared definitions for the bit plotter / bit pattern player pair, so buffer
// depth and bit rate stay matched on both sides.
package bit_plotter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int DEFAULT_ADDR_WIDTH = 14;
    localparam int DEFAULT_PRESCALE   = 32768;

    // Prescaler counter width; a prescale of 1 still needs a 1-bit counter.
    function automatic int prescale_width(input int prescale);
        return (prescale > 1) ? $clog2(prescale) : 1;
    endfunction

endpackage

// File: rtl/bit_buffer_ram.sv
// 1-bit wide simple dual-port pattern buffer: one write port, one read port,
// synchronous read-first with one cycle of read latency.
module bit_buffer_ram
    import bit_plotter_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic                  wr_data_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic                  rd_data_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic mem_q [DEPTH];
    logic rd_data_q;

    // No reset: contents and read register must stay inferable as block RAM.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/bit_pattern_player.sv
// Replays a host-loaded bit pattern as a serial stream, one bit per PRESCALE
// clocks, in one-shot or looped mode.
module bit_pattern_player
    import bit_plotter_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int PRESCALE   = DEFAULT_PRESCALE
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  loadEnable,
    input  logic [ADDR_WIDTH-1:0] loadAddress,
    input  logic                  loadData,
    input  logic [ADDR_WIDTH-1:0] length,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  loop,
    output logic                  bitOut,
    output logic                  bitValid,
    output logic                  busy,
    output logic                  done
);

    localparam int              PS_W    = prescale_width(PRESCALE);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] last_index_q, last_index_d;
    logic [ADDR_WIDTH-1:0] read_index_q, read_index_d;
    logic                  loop_mode_q, loop_mode_d;
    logic [PS_W-1:0]       presc_q, presc_d;
    logic                  pending_q, pending_d;
    logic                  final_q, final_d;
    logic                  hold_q;
    logic                  rd_en;
    logic                  rd_data;

    bit_buffer_ram #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_buffer (
        .clk       (clk),
        .wr_en_i   (loadEnable),
        .wr_addr_i (loadAddress),
        .wr_data_i (loadData),
        .rd_en_i   (rd_en),
        .rd_addr_i (read_index_q),
        .rd_data_o (rd_data)
    );

    always_comb begin
        state_d      = state_q;
        last_index_d = last_index_q;
        loop_mode_d  = loop_mode_q;
        read_index_d = read_index_q;
        presc_d      = presc_q;
        final_d      = final_q;
        pending_d    = 1'b0;
        rd_en        = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d      = RUN;
                    last_index_d = length;
                    loop_mode_d  = loop;
                    read_index_d = '0;
                    presc_d      = '0;
                    final_d      = 1'b0;
                end
            end
            RUN: begin
                presc_d = (presc_q == PS_LAST) ? '0 : presc_q + PS_W'(1);
                if (stop) begin
                    // Dropping pending_d here cancels any read issued this cycle.
                    state_d = IDLE;
                end else begin
                    if (presc_q == '0 && !final_q) begin
                        rd_en     = 1'b1;
                        pending_d = 1'b1;
                        if (read_index_q != last_index_q) begin
                            read_index_d = read_index_q + ADDR_WIDTH'(1);
                        end else if (loop_mode_q) begin
                            read_index_d = '0;
                        end else begin
                            final_d = 1'b1;
                        end
                    end
                    if (pending_q && final_q) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q      <= IDLE;
            last_index_q <= '0;
            loop_mode_q  <= 1'b0;
            read_index_q <= '0;
            presc_q      <= '0;
            pending_q    <= 1'b0;
            final_q      <= 1'b0;
            hold_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_index_q <= last_index_d;
            loop_mode_q  <= loop_mode_d;
            read_index_q <= read_index_d;
            presc_q      <= presc_d;
            pending_q    <= pending_d;
            final_q      <= final_d;
            if (pending_q) begin
                hold_q <= rd_data;
            end
        end
    end

    // The RAM read register supplies the fresh bit; hold_q keeps it afterwards.
    assign bitOut   = pending_q ? rd_data : hold_q;
    assign bitValid = pending_q;
    assign done     = pending_q & final_q;
    assign busy     = (state_q == RUN);

endmodule

// File: tb/tb_bit_pattern_player.sv
// Directed bench for bit_pattern_player: offset-based playback model checked
// every cycle, plus literal tables for each scenario.
module tb_bit_pattern_player;

    localparam int AW    = 14;
    localparam int P     = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          resetN = 1'b0;
    logic          loadEnable = 1'b0;
    logic [AW-1:0] loadAddress = '0;
    logic          loadData = 1'b0;
    logic [AW-1:0] length = '0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          loop = 1'b0;
    logic          bitOut, bitValid, busy, done;
    logic          bitOut1, bitValid1, busy1, done1;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    bit_pattern_player #(.ADDR_WIDTH(AW), .PRESCALE(P)) dut (
        .clk(clk), .resetN(resetN), .loadEnable(loadEnable), .loadAddress(loadAddress),
        .loadData(loadData), .length(length), .start(start), .stop(stop), .loop(loop),
        .bitOut(bitOut), .bitValid(bitValid), .busy(busy), .done(done)
    );

    bit_pattern_player #(.ADDR_WIDTH(AW), .PRESCALE(1)) dut1 (
        .clk(clk), .resetN(resetN), .loadEnable(loadEnable), .loadAddress(loadAddress),
        .loadData(loadData), .length(length), .start(start), .stop(stop), .loop(loop),
        .bitOut(bitOut1), .bitValid(bitValid1), .busy(busy1), .done(done1)
    );

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Model: offset o counts cycles from the cycle start was sampled (o=0).
    // Strobe n lands at o = 2 + n*P and carries the pattern bit as it was in
    // the buffer during cycle o-1; a stop in cycle s suppresses everything after s.
    logic m_mem [DEPTH];
    bit   m_active = 1'b0;
    bit   m_stopped = 1'b0;
    bit   m_loop = 1'b0;
    int   m_off = 0;
    int   m_len = 0;
    int   m_n = 0;
    logic e_bit = 1'b0, e_valid = 1'b0, e_busy = 1'b0, e_done = 1'b0;

    task automatic model_step();
        if (!resetN) begin
            m_active = 1'b0;
            e_bit = 1'b0; e_valid = 1'b0; e_busy = 1'b0; e_done = 1'b0;
            return;
        end
        if (m_active && stop && e_busy) m_stopped = 1'b1;
        if (!m_active && start && !stop) begin
            m_active = 1'b1; m_off = 0; m_len = int'(length); m_loop = loop; m_stopped = 1'b0;
        end
        e_valid = 1'b0; e_done = 1'b0; e_busy = 1'b0;
        if (m_active) begin
            m_off++;
            m_n = (m_off - 2) / P;
            if (!m_stopped && m_off >= 2 && ((m_off - 2) % P == 0) && (m_loop || m_n <= m_len)) begin
                e_valid = 1'b1;
                e_bit   = m_mem[m_n % (m_len + 1)];
                e_done  = !m_loop && (m_n == m_len);
            end
            e_busy = !m_stopped && (m_loop || m_off <= 2 + m_len * P);
            if (!e_busy) m_active = 1'b0;
        end
        if (loadEnable) m_mem[loadAddress] = loadData;
    endtask

    initial forever begin
        @(posedge clk or negedge resetN);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (resetN && chk_en) begin
            check_bit("cmp_valid", bitValid, e_valid);
            check_bit("cmp_bit", bitOut, e_bit);
            check_bit("cmp_busy", busy, e_busy);
            check_bit("cmp_done", done, e_done);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_bit(input int addr, input logic d);
        loadEnable = 1'b1; loadAddress = AW'(addr); loadData = d;
        step();
        loadEnable = 1'b0;
    endtask

    // Called in cycle 0; returns early in cycle 1.
    task automatic pulse_start(input int len, input logic lp);
        length = AW'(len); loop = lp; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) step();
    endtask

    task automatic oneshot_table(input string tag);
        logic ev;
        pulse_start(3, 1'b0);
        for (int o = 1; o <= 16; o++) begin
            @(negedge clk);
            ev = (o == 2 || o == 6 || o == 10 || o == 14);
            check_bit({tag, "_valid"}, bitValid, ev);
            if (ev) check_bit({tag, "_bit"}, bitOut, (o == 6) ? 1'b0 : 1'b1);
            check_bit({tag, "_done"}, done, o == 14);
            check_bit({tag, "_busy"}, busy, o <= 14);
            step();
        end
    endtask

    initial begin
        logic pat [4];
        pat = '{1'b1, 1'b0, 1'b1, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        check_bit("rst_bitOut", bitOut, 1'b0);
        check_bit("rst_bitValid", bitValid, 1'b0);
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_done", done, 1'b0);
        #2 resetN = 1'b1;
        step();
        chk_en = 1'b1;

        for (int i = 0; i < 4; i++) load_bit(i, pat[i]);
        idle_cycles(2);

        oneshot_table("os");
        idle_cycles(2);

        // Looped; length/loop changes after start must be ignored.
        pulse_start(3, 1'b1);
        length = '0; loop = 1'b0;
        for (int o = 1; o <= 28; o++) begin
            @(negedge clk);
            if (o >= 2 && ((o - 2) % 4 == 0)) begin
                check_bit("loop_valid", bitValid, 1'b1);
                check_bit("loop_bit", bitOut, pat[((o - 2) / 4) % 4]);
            end else begin
                check_bit("loop_valid", bitValid, 1'b0);
            end
            check_bit("loop_done", done, 1'b0);
            check_bit("loop_busy", busy, 1'b1);
            step();
        end
        stop = 1'b1; step(); stop = 1'b0;
        idle_cycles(3);

        // Stop in cycle 7 of a one-shot.
        pulse_start(3, 1'b0);
        for (int o = 1; o <= 14; o++) begin
            stop = (o == 7);
            @(negedge clk);
            check_bit("stop_valid", bitValid, o == 2 || o == 6);
            if (o >= 6) check_bit("stop_bit", bitOut, 1'b0);
            check_bit("stop_done", done, 1'b0);
            check_bit("stop_busy", busy, o <= 7);
            step();
        end
        stop = 1'b0;
        idle_cycles(2);

        // Asynchronous reset mid-run, during the cycle a strobe is due.
        pulse_start(3, 1'b0);
        idle_cycles(5);
        #2 resetN = 1'b0;
        #1;
        check_bit("arst_bitOut", bitOut, 1'b0);
        check_bit("arst_bitValid", bitValid, 1'b0);
        check_bit("arst_busy", busy, 1'b0);
        check_bit("arst_done", done, 1'b0);
        @(posedge clk); @(posedge clk);
        #3 resetN = 1'b1;
        step();
        oneshot_table("replay");
        idle_cycles(2);

        // Read-first: address 2 is rewritten 0->1 in the cycle it is read.
        load_bit(2, 1'b0);
        pulse_start(3, 1'b0);
        for (int o = 1; o <= 16; o++) begin
            if (o == 9) begin
                loadEnable = 1'b1; loadAddress = AW'(2); loadData = 1'b1;
            end else begin
                loadEnable = 1'b0;
            end
            @(negedge clk);
            if (o == 10) begin
                check_bit("rf_valid", bitValid, 1'b1);
                check_bit("rf_old_bit", bitOut, 1'b0);
            end
            step();
        end
        loadEnable = 1'b0;
        pulse_start(3, 1'b0);
        for (int o = 1; o <= 16; o++) begin
            @(negedge clk);
            if (o == 10) check_bit("rf_new_bit", bitOut, 1'b1);
            step();
        end
        idle_cycles(2);

        // start and stop together in IDLE: stop wins.
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        for (int o = 1; o <= 3; o++) begin
            @(negedge clk);
            check_bit("ss_busy", busy, 1'b0);
            check_bit("ss_busy1", busy1, 1'b0);
            step();
        end

        // PRESCALE=1, length=0, loop=1: one bit every cycle from cycle 2.
        pulse_start(0, 1'b1);
        for (int o = 1; o <= 10; o++) begin
            @(negedge clk);
            check_bit("p1_valid", bitValid1, o >= 2);
            if (o >= 2) check_bit("p1_bit", bitOut1, 1'b1);
            check_bit("p1_busy", busy1, 1'b1);
            check_bit("p1_done", done1, 1'b0);
            step();
        end
        stop = 1'b1; step(); stop = 1'b0;
        idle_cycles(3);
        @(negedge clk);
        check_bit("p1_end_busy", busy1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
